// File: rtl/full_band_elastic_fifo.sv
// DEPTH-entry valid/ready elastic FIFO, one transfer per cycle, with count, almost_full and optional empty bypass.
// Latency 1 cycle registered, 0 in fall-through when empty; ready_o depends only on stored count (full blocks push even on pop).
module full_band_elastic_fifo #(
  parameter int DW          = 16,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = DEPTH - 1,
  parameter int FALLTHROUGH = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DW-1:0]                din,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DW-1:0]                dout,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit FT = (FALLTHROUGH != 0);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic push;
  logic bypass;
  logic store;
  logic pop_mem;

  always_comb begin
    empty   = (count_q == '0);
    ready_o = (count_q != FULL_CNT);

    // In fall-through mode an empty buffer presents the incoming word directly.
    if (FT && empty) begin
      valid_o = valid_i;
      dout    = valid_i ? din : mem_q[rd_ptr_q];
    end else begin
      valid_o = !empty;
      dout    = mem_q[rd_ptr_q];
    end

    push    = valid_i & ready_o;
    bypass  = push & FT & empty & ready_i;
    store   = push & ~bypass;
    pop_mem = valid_o & ready_i & ~empty;

    mem_d = mem_q;
    if (store) begin
      mem_d[wr_ptr_q] = din;
    end

    wr_ptr_d = store   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_mem ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (store && !pop_mem) begin
      count_d = count_q + CW'(1);
    end else if (pop_mem && !store) begin
      count_d = count_q - CW'(1);
    end

    count       = count_q;
    almost_full = (count_q >= AF_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_full_band_elastic_fifo.sv
// Bench: registered and fall-through instances driven in lockstep, each checked against a queue model.
module tb_full_band_elastic_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid_i;
  logic          ready_i;
  logic [DW-1:0] din;

  logic          r_ready, r_valid, r_af;
  logic [DW-1:0] r_dout;
  logic [CW-1:0] r_count;
  logic          f_ready, f_valid, f_af;
  logic [DW-1:0] f_dout;
  logic [CW-1:0] f_count;

  full_band_elastic_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .FALLTHROUGH(0)) u_reg (
    .clk(clk), .rst(rst), .din(din), .valid_i(valid_i), .ready_o(r_ready),
    .dout(r_dout), .valid_o(r_valid), .ready_i(ready_i), .count(r_count), .almost_full(r_af)
  );

  full_band_elastic_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .FALLTHROUGH(1)) u_ft (
    .clk(clk), .rst(rst), .din(din), .valid_i(valid_i), .ready_o(f_ready),
    .dout(f_dout), .valid_o(f_valid), .ready_i(ready_i), .count(f_count), .almost_full(f_af)
  );

  logic [DW-1:0] qr[$];
  logic [DW-1:0] qf[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the queue contents alone.
  task automatic check_outs(input bit ft);
    int            n;
    logic [DW-1:0] head;
    logic          ev;
    string         p;
    p    = ft ? "ft" : "reg";
    n    = ft ? qf.size() : qr.size();
    head = din;
    if (n != 0) head = ft ? qf[0] : qr[0];
    ev   = (n != 0) || (ft && valid_i);
    chk({p, ".valid_o"}, ft ? f_valid : r_valid, ev);
    chk({p, ".ready_o"}, ft ? f_ready : r_ready, n != DEPTH);
    chk({p, ".count"}, ft ? f_count : r_count, n);
    chk({p, ".almost_full"}, ft ? f_af : r_af, n >= AF);
    if (ev) chk({p, ".dout"}, ft ? f_dout : r_dout, head);
  endtask

  task automatic model_update(input bit ft);
    logic [DW-1:0] q[$];
    int n;
    logic ev, push, pop;
    if (ft) q = qf; else q = qr;
    if (rst) begin
      q.delete();
    end else begin
      n    = q.size();
      ev   = (n != 0) || (ft && valid_i);
      push = valid_i && (n != DEPTH);
      pop  = ev && ready_i;
      if (!(ft && n == 0 && push && ready_i)) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(din);
      end
    end
    if (ft) qf = q; else qr = q;
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    #1;
    check_outs(1'b0);
    check_outs(1'b1);
    @(posedge clk);
    model_update(1'b0);
    model_update(1'b1);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic r, input logic [DW-1:0] d);
    valid_i = v;
    ready_i = r;
    din     = d;
    step();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".reg.count"}, r_count, 0);
    chk({tag, ".reg.valid_o"}, r_valid, 0);
    chk({tag, ".reg.ready_o"}, r_ready, 1);
    chk({tag, ".reg.almost_full"}, r_af, 0);
    chk({tag, ".reg.dout"}, r_dout, 0);
    chk({tag, ".ft.count"}, f_count, 0);
    chk({tag, ".ft.dout"}, f_dout, 0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; din = 16'h5A5A;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0; din = '0;
    #1;
    check_reset("reset");

    // Fill with downstream stalled, then try to overfill.
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, DW'(i));
    #1;
    chk("fill.reg.count", r_count, 4);
    chk("fill.reg.ready_o", r_ready, 0);
    chk("fill.reg.almost_full", r_af, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0009);
    drive(1'b1, 1'b1, 16'h0009);  // full: a pop this cycle must not admit a push

    // Drain, then refill across the pointer wrap.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);
    #1;
    chk("drain.reg.count", r_count, 0);
    chk("drain.reg.valid_o", r_valid, 0);
    for (int i = 5; i <= 7; i++) drive(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);

    // Back-to-back streaming.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, DW'(16'h0100 + i));
      if (i > 0) begin
        chk("stream.reg.count", r_count, 1);
        chk("stream.reg.valid_o", r_valid, 1);
      end
      chk("stream.ft.count", f_count, 0);
    end
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, '0);

    // Fall-through bypass, then store with downstream stalled.
    valid_i = 1'b1; ready_i = 1'b1; din = 16'hBEEF;
    #1;
    chk("bypass.ft.valid_o", f_valid, 1);
    chk("bypass.ft.dout", f_dout, 16'hBEEF);
    #1;
    drive(1'b1, 1'b1, 16'hBEEF);
    chk("bypass.ft.count", f_count, 0);
    drive(1'b1, 1'b0, 16'hBEEF);
    valid_i = 1'b0; ready_i = 1'b0; din = 16'h1234;
    #1;
    chk("store.ft.count", f_count, 1);
    chk("store.ft.dout", f_dout, 16'hBEEF);
    #1;
    drive(1'b0, 1'b0, 16'h1234);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);

    // Simultaneous push and pop at count 2.
    drive(1'b1, 1'b0, 16'h0011);
    drive(1'b1, 1'b0, 16'h0022);
    drive(1'b1, 1'b1, 16'h00AA);
    chk("simul.reg.count", r_count, 2);
    chk("simul.reg.head", r_dout, 16'h0022);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(16'h0030 + i));
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0077);
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0; din = '0;
    #1;
    check_reset("midrst");
    #1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), DW'($urandom));
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_band_elastic_fifo.md
Name: full_band_elastic_fifo

Overview:
Parametrised successor to the single-entry half-band elastic buffer. DEPTH-entry valid/ready FIFO that sustains one transfer per cycle, with simultaneous push and pop. Adds occupancy count, programmable almost-full flag and an optional empty-bypass (fall-through) mode. Sits on NoC router input/output channels and link pipeline stages, between any valid/ready producer and consumer.

Parameters:
DW, 16, data width in bits
DEPTH, 4, number of storage entries; power of two, >= 2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
FALLTHROUGH, 0, 0 = registered mode (data always passes through storage); 1 = bypass when empty

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  DW  upstream data
valid_i  input  1  upstream data valid
ready_o  output  1  buffer can accept
dout  output  DW  downstream data
valid_o  output  1  downstream data valid
ready_i  input  1  downstream can accept
count  output  $clog2(DEPTH+1)  current stored entries
almost_full  output  1  count >= AF_LEVEL

Behaviour:
- Reset: one clk edge with rst=1 clears wr_ptr, rd_ptr and count, and zeroes all storage entries. After reset: count=0, valid_o=0, ready_o=1, almost_full=0, dout=0. rst overrides any same-cycle push/pop. Reset mid-stream discards all contents.
- push = valid_i & ready_o. pop = valid_o & ready_i.
- ready_o = (count != DEPTH). It depends only on registered state, with no combinational path from ready_i. When full, a same-cycle pop does not enable a push.
- Registered mode (FALLTHROUGH=0):
  - valid_o = (count != 0).
  - dout = mem[rd_ptr].
  - Latency: a word pushed at edge N is visible at dout after edge N.
- Fall-through mode (FALLTHROUGH=1):
  - When count==0: valid_o = valid_i and dout = din, combinationally.
  - If ready_i is also 1, the word passes straight through. Nothing is written and count stays 0.
  - If ready_i=0, the word is stored normally.
  - When count!=0, behaviour is identical to registered mode.
- Storage on push (not bypassed): mem[wr_ptr] <= din, wr_ptr increments.
- On pop from storage: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 on a stored push only.
  - -1 on a pop from storage only.
  - Unchanged on simultaneous push and pop, or on bypass.
  - Never exceeds DEPTH and never underflows; this is guaranteed by ready_o and valid_o gating.
- almost_full = (count >= AF_LEVEL). It is registered-state derived, with no dependence on valid_i.
- Ordering: strict FIFO. No duplication or loss under any ready_i pattern.
- dout while valid_o=0 holds mem[rd_ptr] and is don't-care to consumers. Benches check dout only when valid_o=1.
- Throughput: with ready_i held at 1 and valid_i held at 1, one word per cycle in both modes. count is steady at 1 in registered mode and at 0 in fall-through mode.
- Reference-model equivalence: with DEPTH=... and FALLTHROUGH=0 there is no full-cycle stall every other beat, unlike the half-band stage. The back-to-back stream must show no bubbles.

Test Plan:
- Reset, then fill: DW=16, DEPTH=4, ready_i=0. Push 0x0001..0x0004 on consecutive cycles. Expect count 1,2,3,4 and almost_full=1 from count=3. ready_o=0 after the 4th push. A 5th valid_i=1 for 3 cycles is not accepted; count stays 4.
- Drain with wrap: from the full state, ready_i=1 for 4 cycles. Expect dout 0x0001..0x0004 with valid_o=1, ending at count=0, valid_o=0. Then push 0x0005..0x0007 and pop them: order is preserved across the pointer wrap.
- Streaming: valid_i=1 and ready_i=1 for 20 cycles, data incrementing from 0x0100. Expect 20 outputs 0x0100..0x0113 on consecutive cycles with no bubbles. count=1 steady with FALLTHROUGH=0, count=0 with FALLTHROUGH=1.
- Fall-through: FALLTHROUGH=1, empty, din=0xBEEF, valid_i=1, ready_i=1. Expect valid_o=1 and dout=0xBEEF in the same cycle, with count staying 0. Repeat with ready_i=0: the word is stored, count=1, and dout=0xBEEF is held next cycle.
- Simultaneous push/pop at count=2: push 0x00AA while popping the head. Expect count stays 2, the head advances and 0x00AA is appended at the tail.
- Reset mid-operation: at count=3, assert rst for 1 cycle concurrently with valid_i=1 and ready_i=1. Expect next-cycle count=0, valid_o=0, ready_o=1, almost_full=0, dout=0, and no pushed word retained.
